// File: rtl/alu_mc.sv
// Multi-cycle ALU: operand A is loaded from a shared bus, start captures B and the opcode,
// and the result plus {Z,N,C,V} flags are committed to G after a 1-, s- or WIDTH-cycle execution.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             A_ena,
  input  logic             start,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUout,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   wa_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   g_q;
  logic [3:0]         flags_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_dif;
  logic [WIDTH-1:0]   shl_val;
  logic [WIDTH-1:0]   shr_val;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               last;

  assign add_sum  = {1'b0, wa_q} + {1'b0, b_q};
  assign sub_dif  = {1'b0, wa_q} - {1'b0, b_q};
  assign shl_val  = {wa_q[WIDTH-2:0], 1'b0};
  assign shr_val  = {1'b0, wa_q[WIDTH-1:1]};

  // One shift-add step: the multiplier sits in the low half and drains out to the right.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, wa_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    last  = 1'b1;
    case (op_q)
      OP_ADD: begin
        res   = add_sum[WIDTH-1:0];
        res_c = add_sum[WIDTH];
        res_v = (wa_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != wa_q[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_dif[WIDTH-1:0];
        res_c = ~sub_dif[WIDTH];
        res_v = (wa_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != wa_q[WIDTH-1]);
      end
      OP_AND: res = wa_q & b_q;
      OP_OR:  res = wa_q | b_q;
      OP_XOR: res = wa_q ^ b_q;
      OP_SHL: begin
        last = (cnt_q <= CW'(1));
        if (cnt_q == '0) begin
          res = wa_q;
        end else begin
          res   = shl_val;
          res_c = wa_q[WIDTH-1];
        end
      end
      OP_SHR: begin
        last = (cnt_q <= CW'(1));
        if (cnt_q == '0) begin
          res = wa_q;
        end else begin
          res   = shr_val;
          res_c = wa_q[0];
        end
      end
      OP_MUL: begin
        last  = (cnt_q == '0);
        res   = mul_next[WIDTH-1:0];
        res_c = |mul_next[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      wa_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (A_ena) a_q <= bus;
          if (start) begin
            // wa_q takes the pre-edge A, so a simultaneous A_ena load does not affect this operation.
            b_q    <= bus;
            op_q   <= op_t'(op);
            wa_q   <= a_q;
            prod_q <= {{WIDTH{1'b0}}, bus};
            cnt_q  <= (op_t'(op) == OP_MUL) ? '1 : bus[CW-1:0];
            busy_q <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (last) begin
            g_q     <= res;
            flags_q <= {~|res, res[WIDTH-1], res_c, res_v};
            done_q  <= 1'b1;
            state   <= S_DONE;
          end else begin
            case (op_q)
              OP_SHL:  wa_q   <= shl_val;
              OP_SHR:  wa_q   <= shr_val;
              OP_MUL:  prod_q <= mul_next;
              default: ;
            endcase
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ALUout = g_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=16): vector table plus hand-written multi-cycle sequences,
// with a scoreboard queue checked whenever done pulses.
module tb_alu_mc;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus = '0;
  logic        A_ena = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic        busy;
  logic        done;
  logic [15:0] ALUout;
  logic [3:0]  flags;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .A_ena(A_ena), .start(start), .op(op),
    .busy(busy), .done(done), .ALUout(ALUout), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;
    int          n;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          n;
    int          start_edge;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: compares each done pulse against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("result", 32'(ALUout), 32'(e.res));
          check("flags", 32'(flags), 32'(e.fl));
          check("latency", 32'(cyc - e.start_edge), 32'(e.n));
          check("busy_len", 32'(busy_run), 32'(e.n + 1));
        end
      end
      if (!busy) busy_run = 0;
    end
  end

  // All driver tasks begin and end just after a falling edge.
  task automatic load_a(input logic [15:0] v);
    A_ena = 1'b1;
    bus   = v;
    @(negedge clk);
    A_ena = 1'b0;
  endtask

  task automatic launch(input logic [2:0] o, input logic [15:0] b,
                        input logic [15:0] res, input logic [3:0] fl, input int n);
    exp_t e;
    e.res = res;
    e.fl = fl;
    e.n = n;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    bus   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d operations still outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{ADD,  16'h0F00, 16'h000F, 16'h0F0F, 4'b0000, 1},
      '{SUB,  16'h00F0, 16'h000F, 16'h00E1, 4'b0010, 1},
      '{SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b0100, 1},
      '{SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1},
      '{SUB,  16'h1234, 16'h1234, 16'h0000, 4'b1010, 1},
      '{ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1},
      '{ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1},
      '{AND_, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 1},
      '{OR_,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1},
      '{XOR_, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1},
      '{SHL,  16'h8001, 16'h0004, 16'h0010, 4'b0000, 4},
      '{SHR,  16'h0003, 16'h0001, 16'h0001, 4'b0010, 1},
      '{SHR,  16'h1234, 16'h0010, 16'h1234, 4'b0000, 1},
      '{SHL,  16'h0001, 16'h000F, 16'h8000, 4'b0100, 15},
      '{SHR,  16'hC000, 16'h000F, 16'h0001, 4'b0010, 15},
      '{MUL,  16'h0100, 16'h0100, 16'h0000, 4'b1010, 16},
      '{MUL,  16'h00FF, 16'h0003, 16'h02FD, 4'b0000, 16},
      '{MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 16}
    };

    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_aluout", 32'(ALUout), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      load_a(vecs[i].a);
      launch(vecs[i].op, vecs[i].b, vecs[i].res, vecs[i].fl, vecs[i].n);
      wait_idle();
    end

    // start and A_ena together: operation uses old A, A takes the bus value.
    load_a(16'h0005);
    A_ena = 1'b1;
    launch(ADD, 16'h0003, 16'h0008, 4'b0000, 1);
    A_ena = 1'b0;
    wait_idle();
    launch(ADD, 16'h0000, 16'h0003, 4'b0000, 1);
    wait_idle();

    // start and A_ena mid-MUL are ignored.
    load_a(16'h0003);
    launch(MUL, 16'h0005, 16'h000F, 4'b0000, 16);
    repeat (3) @(negedge clk);
    A_ena = 1'b1;
    start = 1'b1;
    op    = ADD;
    bus   = 16'hFFFF;
    @(negedge clk);
    A_ena = 1'b0;
    start = 1'b0;
    wait_idle();
    launch(ADD, 16'h0000, 16'h0003, 4'b0000, 1);
    wait_idle();

    // Asynchronous reset mid-MUL aborts without a commit or done pulse.
    load_a(16'h0007);
    launch(MUL, 16'h0009, 16'h003F, 4'b0000, 16);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_aluout", 32'(ALUout), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_abort", 32'(busy), 32'd0);

    // First start is accepted on the first rising edge after reset release.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    launch(ADD, 16'h0042, 16'h0042, 4'b0000, 1);
    wait_idle();
    load_a(16'h1111);
    launch(ADD, 16'h2222, 16'h3333, 4'b0000, 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
